// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 7-segment scan controller: active-low segment
// patterns (bit 7 = dp, 1 = off), the scan FSM states and the width helper
// for the prescale counter.
package seven_seg_pkg;

  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic {
    OFF  = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Bits needed to hold 0..prescale-1.
  function automatic int cnt_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-low g..a segments. Codes A..F render as all-off.
module bcd_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Pure lookup; anything outside 0..9 is dark.
  always_comb begin
    seg_o = SEG_OFF[6:0];
    case (bcd_i)
      4'd0:    seg_o = SEG_0[6:0];
      4'd1:    seg_o = SEG_1[6:0];
      4'd2:    seg_o = SEG_2[6:0];
      4'd3:    seg_o = SEG_3[6:0];
      4'd4:    seg_o = SEG_4[6:0];
      4'd5:    seg_o = SEG_5[6:0];
      4'd6:    seg_o = SEG_6[6:0];
      4'd7:    seg_o = SEG_7[6:0];
      4'd8:    seg_o = SEG_8[6:0];
      4'd9:    seg_o = SEG_9[6:0];
      default: seg_o = SEG_OFF[6:0];
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with a
// tear-free valid/ready frame buffer. Outputs are registered from the
// next-state cnt/idx so they line up with the cnt/idx of the same cycle.
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading-zero suppression).
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_bcd,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic                  blank,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int CW = cnt_width(PRESCALE);
  localparam int IW = (DIGITS <= 1) ? 1 : $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  pend_q, pend_d;
  logic [4*DIGITS-1:0]   pend_bcd_q, pend_bcd_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic [4*DIGITS-1:0]   act_bcd_q, act_bcd_d;
  logic [DIGITS-1:0]     act_dp_q, act_dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  fd_q, fd_d;
  logic                  wrap, commit;
  logic [3:0]            cur_bcd;
  logic [6:0]            dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0]     mask_q, mask_d;

  // Zeros above the most significant nonzero digit; digit 0 always shown.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] bcd);
    logic zero_run;
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run && (bcd[4*i +: 4] == 4'd0);
      lz_mask[i] = zero_run;
    end
  endfunction
`endif

  assign load_ready = ~pend_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;

  // Decoder sees the digit that will be lit in the coming cycle.
  assign cur_bcd = act_bcd_q[4*idx_d +: 4];

  bcd_to_7seg u_dec (
    .bcd_i (cur_bcd),
    .seg_o (dec_seg)
  );

  // Next-state: scan counters, load buffer capture and frame commit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    pend_bcd_d = pend_bcd_q;
    pend_dp_d  = pend_dp_q;
    act_bcd_d  = act_bcd_q;
    act_dp_d   = act_dp_q;
`ifdef LEADING_ZERO_BLANK_EN
    mask_d     = mask_q;
`endif
    wrap   = (state_q == SCAN) && !blank && (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);
    commit = pend_q && (wrap || (state_q == OFF));

    state_d = blank ? OFF : SCAN;
    if ((state_q == OFF) || blank) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Accept and commit are exclusive: accept needs pend_q=0, commit pend_q=1.
    if (load_valid && !pend_q) begin
      pend_d     = 1'b1;
      pend_bcd_d = load_bcd;
      pend_dp_d  = load_dp;
    end else if (commit) begin
      pend_d    = 1'b0;
      act_bcd_d = pend_bcd_q;
      act_dp_d  = pend_dp_q;
`ifdef LEADING_ZERO_BLANK_EN
      mask_d    = lz_mask(pend_bcd_q);
`endif
    end
    fd_d = wrap;
  end

  // Output drive for the coming cycle; cnt 0 is a dark guard slot.
  // A commit always lands on a cnt 0 cycle, so current active data is safe.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    if ((state_d == SCAN) && (cnt_d != '0)) begin
      an_d  = ~(DIGITS'(1) << idx_d);
      seg_d = {~act_dp_q[idx_d], dec_seg};
`ifdef LEADING_ZERO_BLANK_EN
      if (mask_q[idx_d]) seg_d[6:0] = 7'h7F;
`endif
    end
  end

  // State and output registers; reset drops both buffered and shown frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SCAN;
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      pend_bcd_q <= '0;
      pend_dp_q  <= '0;
      act_bcd_q  <= '1;
      act_dp_q   <= '0;
      an_q       <= '1;
      seg_q      <= SEG_OFF;
      fd_q       <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      mask_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_bcd_q <= pend_bcd_d;
      pend_dp_q  <= pend_dp_d;
      act_bcd_q  <= act_bcd_d;
      act_dp_q   <= act_dp_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      fd_q       <= fd_d;
`ifdef LEADING_ZERO_BLANK_EN
      mask_q     <= mask_d;
`endif
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with DIGITS=4, PRESCALE=4.
// Expected segment patterns are hand-derived from the decode table.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_bcd;
  logic [3:0]  load_dp;
  logic        blank;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  int n_chk  = 0;
  int n_pass = 0;

  seven_seg_scan_ctrl #(.DIGITS(4), .PRESCALE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_bcd   (load_bcd),
    .load_dp    (load_dp),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a frame and hold valid until the handshake edge.
  task automatic load(input logic [15:0] bcd, input logic [3:0] dp);
    int n;
    load_bcd   = bcd;
    load_dp    = dp;
    load_valid = 1'b1;
    n = 0;
    while (!load_ready && n < 40) begin tick(); n++; end
    if (n >= 40) chk("load_timeout", 32'd0, 32'd1);
    tick();
    load_valid = 1'b0;
  endtask

  // Advance to the next frame_done cycle (never the current one).
  task automatic wait_fd();
    int n;
    n = 0;
    do begin tick(); n++; end while (!frame_done && n < 40);
    if (!frame_done) chk("fd_timeout", 32'd0, 32'd1);
  endtask

  // Check 16 cycles starting at the current cycle (idx 0, cnt 0), then the
  // frame_done pulse that opens the next frame. e[i] is digit i's pattern.
  task automatic check_frame(input string tag, input logic [3:0][7:0] e, input logic fd0);
    logic [3:0] ea;
    logic [7:0] es;
    for (int k = 0; k < 16; k++) begin
      if (k % 4 == 0) begin
        ea = 4'hF;
        es = 8'hFF;
      end else begin
        ea = ~(4'b0001 << (k / 4));
        es = e[k / 4];
      end
      chk({tag, "_anseg"}, {20'd0, an, seg}, {20'd0, ea, es});
      chk({tag, "_fd"}, {31'd0, frame_done}, {31'd0, (k == 0) ? fd0 : 1'b0});
      tick();
    end
    chk({tag, "_fd_wrap"}, {31'd0, frame_done}, 32'd1);
  endtask

  initial begin
    logic [3:0][7:0] e_lz;
    int n;
    rst = 1'b1; load_valid = 1'b0; load_bcd = '0; load_dp = '0; blank = 1'b0;

    // Reset
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_an", {28'd0, an}, 32'hF);
      chk("rst_seg", {24'd0, seg}, 32'hFF);
      chk("rst_ready", {31'd0, load_ready}, 32'd1);
      chk("rst_fd", {31'd0, frame_done}, 32'd0);
    end
    rst = 1'b0;
    check_frame("rstfrm", {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1'b0);

    // Basic frame 1234
    load(16'h1234, 4'b0000);
    chk("basic_ready_lo", {31'd0, load_ready}, 32'd0);
    wait_fd();
    chk("basic_ready_hi", {31'd0, load_ready}, 32'd1);
    check_frame("basic", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 1'b1);
    check_frame("basic2", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 1'b1);

    // Back-to-back: 5678 then 9999 held valid
    load_bcd = 16'h5678; load_dp = 4'b0000; load_valid = 1'b1;
    tick();
    load_bcd = 16'h9999;
    n = 0;
    do begin
      tick(); n++;
      if (!frame_done) chk("b2b_ready_lo", {31'd0, load_ready}, 32'd0);
    end while (!frame_done && n < 40);
    chk("b2b_wrap_seen", {31'd0, frame_done}, 32'd1);
    check_frame("f5678", {8'h92, 8'h82, 8'hF8, 8'h80}, 1'b1);
    check_frame("f9999", {8'h90, 8'h90, 8'h90, 8'h90}, 1'b1);
    load_valid = 1'b0;

    // Invalid code with dp
    load(16'hA000, 4'b1000);
    wait_fd();
    check_frame("inv", {8'h7F, 8'hC0, 8'hC0, 8'hC0}, 1'b1);

    // Blank mid-frame at idx 2, cnt 2
    repeat (10) tick();
    chk("pre_blank", {20'd0, an, seg}, {20'd0, 4'b1011, 8'hC0});
    blank = 1'b1;
    tick();
    chk("blank_anseg", {20'd0, an, seg}, {20'd0, 4'hF, 8'hFF});
    chk("blank_fd", {31'd0, frame_done}, 32'd0);
    load_bcd = 16'h0070; load_dp = 4'b0000; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("blank_ready_lo", {31'd0, load_ready}, 32'd0);
    tick();
    chk("blank_commit", {31'd0, load_ready}, 32'd1);
    chk("blank_anseg2", {20'd0, an, seg}, {20'd0, 4'hF, 8'hFF});
    chk("blank_fd2", {31'd0, frame_done}, 32'd0);
    blank = 1'b0;
    tick();
`ifdef LEADING_ZERO_BLANK_EN
    e_lz = {8'hFF, 8'hFF, 8'hF8, 8'hC0};
`else
    e_lz = {8'hC0, 8'hC0, 8'hF8, 8'hC0};
`endif
    check_frame("resume", e_lz, 1'b0);
    check_frame("lzb", e_lz, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
